// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron layer controller.
package neuron_pkg;

  localparam int WEIGHT_W    = 16;
  localparam int SUM_W       = 32;
  localparam int SUM_MIN     = -32768;
  localparam int SUM_MAX     = 32767;
  localparam int ADDR_OFFSET = 32768;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/neuron_sat_addr.sv
// Clamps a signed neuron sum into the 16-bit sigmoid LUT address space.
module neuron_sat_addr
  import neuron_pkg::*;
(
  input  logic signed [SUM_W-1:0] sum,
  output logic [15:0]             addr,
  output logic                    clamped
);

  always_comb begin
    addr    = '0;
    clamped = 1'b0;
    if (sum < SUM_MIN) begin
      addr    = '0;
      clamped = 1'b1;
    end else if (sum > SUM_MAX) begin
      addr    = '1;
      clamped = 1'b1;
    end else begin
      addr = 16'(sum + ADDR_OFFSET);
    end
  end

endmodule

// File: rtl/neuron_layer_ctrl.sv
// Time-multiplexed neuron layer: one neuron per cycle onto a shared sigmoid LUT.
// Optional saturation statistics counter enabled by macro NEURON_SAT_STATS_EN.
module neuron_layer_ctrl
  import neuron_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int LUT_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  x_in,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_idx,
  input  logic [1:0]  cfg_sel,
  input  logic [15:0] cfg_data,
  output logic [13:0] lut_addr,
  input  logic [7:0]  lut_q,
  output logic        out_valid,
  output logic [3:0]  out_idx,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] sat_count
);

  localparam logic [4:0] NUM_N      = 5'(NUM_NEURONS);
  localparam logic [4:0] LAST_ISSUE = 5'(NUM_NEURONS - 1);
  localparam logic [4:0] DRAIN_LAST = 5'(LUT_LATENCY);

  state_t state, state_nxt;
  logic [4:0] cnt;
  logic [2:0] x_lat;
  logic signed [WEIGHT_W-1:0] w_mem [16][4];

  logic                       cfg_ok;
  logic                       issue;
  logic [3:0]                 issue_idx;
  logic [2:0]                 x_sel;
  logic signed [WEIGHT_W-1:0] w_eff [4];
  logic signed [SUM_W-1:0]    sum;
  logic [15:0]                sat_addr;
  logic                       sat_clamped;
  logic [13:0]                addr_d;
  logic [1:0]                 unused_addr_lsb;

  logic       issue_v;
  logic [3:0] issue_idx_q;
  logic       pv   [LUT_LATENCY];
  logic [3:0] pidx [LUT_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST_ISSUE) state_nxt = DRAIN;
      DRAIN:   if (cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Neuron 0 is issued on the start cycle itself, so a same-cycle cfg write
  // must be forwarded around the weight store to reach that first issue.
  always_comb begin
    cfg_ok    = cfg_we && (state == IDLE) && ({1'b0, cfg_idx} < NUM_N);
    issue     = ((state == IDLE) && start) || ((state == RUN) && (cnt != LAST_ISSUE));
    issue_idx = (state == IDLE) ? 4'd0 : cnt[3:0] + 4'd1;
    x_sel     = (state == IDLE) ? x_in : x_lat;
    for (int unsigned s = 0; s < 4; s++) begin
      w_eff[s] = w_mem[issue_idx][s];
      if (cfg_ok && (cfg_idx == issue_idx) && (cfg_sel == 2'(s)))
        w_eff[s] = signed'(cfg_data);
    end
    sum = SUM_W'(w_eff[3]);
    for (int unsigned s = 0; s < 3; s++) begin
      if (x_sel[s]) sum = sum + SUM_W'(w_eff[s]);
    end
  end

  neuron_sat_addr u_sat_addr (
    .sum     (sum),
    .addr    (sat_addr),
    .clamped (sat_clamped)
  );

  assign {addr_d, unused_addr_lsb} = sat_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      x_lat       <= '0;
      lut_addr    <= '0;
      issue_v     <= 1'b0;
      issue_idx_q <= '0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_data    <= '0;
      for (int unsigned k = 0; k < LUT_LATENCY; k++) begin
        pv[k]   <= 1'b0;
        pidx[k] <= '0;
      end
      for (int unsigned n = 0; n < 16; n++) begin
        for (int unsigned s = 0; s < 4; s++) w_mem[n][s] <= '0;
      end
    end else begin
      if (state != state_nxt)                   cnt <= '0;
      else if ((state == RUN) || (state == DRAIN)) cnt <= cnt + 5'd1;

      if ((state == IDLE) && start) x_lat <= x_in;
      if (cfg_ok) w_mem[cfg_idx][cfg_sel] <= signed'(cfg_data);

      issue_v <= issue;
      if (issue) begin
        lut_addr    <= addr_d;
        issue_idx_q <= issue_idx;
      end

      // Last stage lines up with lut_q for the address issued LUT_LATENCY cycles earlier.
      pv[0]   <= issue_v;
      pidx[0] <= issue_idx_q;
      for (int unsigned k = 1; k < LUT_LATENCY; k++) begin
        pv[k]   <= pv[k-1];
        pidx[k] <= pidx[k-1];
      end

      out_valid <= pv[LUT_LATENCY-1];
      if (pv[LUT_LATENCY-1]) begin
        out_idx  <= pidx[LUT_LATENCY-1];
        out_data <= lut_q;
      end
    end
  end

`ifdef NEURON_SAT_STATS_EN
  logic [15:0] sat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      sat_cnt <= '0;
    else if (issue && sat_clamped && (sat_cnt != '1)) sat_cnt <= sat_cnt + 16'd1;
  end

  assign sat_count = sat_cnt;
`else
  logic unused_clamped;
  assign unused_clamped = sat_clamped;
  assign sat_count      = '0;
`endif

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Self-checking bench for neuron_layer_ctrl against a cycle-indexed reference model.
module tb_neuron_layer_ctrl;

  localparam int N = 4;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  x_in = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [1:0]  cfg_sel = '0;
  logic [15:0] cfg_data = '0;
  logic [13:0] lut_addr;
  logic [7:0]  lut_q;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  neuron_layer_ctrl #(.NUM_NEURONS(N), .LUT_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .lut_addr(lut_addr), .lut_q(lut_q),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .done(done), .sat_count(sat_count)
  );

  function automatic logic [7:0] lut_fn(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], a[1:0]} ^ 8'h5A;
  endfunction

  // External LUT: data for an address appears L cycles after the address changes.
  logic [13:0] ah [L];
  always @(posedge clk) begin
    ah[0] <= lut_addr;
    for (int k = 1; k < L; k++) ah[k] <= ah[k-1];
  end
  assign lut_q = lut_fn(ah[L-1]);

  int tests = 0;
  int fails = 0;
  int mw [16][4];
  int exp_sat = 0;
  logic [13:0] ea [N];
  logic [13:0] obs_addr [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nsum(input int i, input logic [2:0] x);
    int s;
    s = mw[i][3];
    for (int b = 0; b < 3; b++) if (x[b]) s += mw[i][b];
    return s;
  endfunction

  function automatic logic [13:0] exp_addr(input int s);
    logic [15:0] t;
    if (s < -32768)     t = 16'h0000;
    else if (s > 32767) t = 16'hFFFF;
    else                t = 16'(s + 32768);
    return t[15:2];
  endfunction

  function automatic logic [15:0] exp_sat_count();
`ifdef NEURON_SAT_STATS_EN
    return (exp_sat > 65535) ? 16'hFFFF : 16'(exp_sat);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic void model_write(input int idx, input int sel, input logic [15:0] d);
    if (idx < N) mw[idx][sel] = int'($signed(d));
  endfunction

  task automatic cfg_write(input int idx, input int sel, input logic [15:0] d);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_sel = 2'(sel); cfg_data = d;
    model_write(idx, sel, d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_lut_addr"},  32'(lut_addr),  0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_idx"},   32'(out_idx),   0);
    chk({tag, "_out_data"},  32'(out_data),  0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_sat_count"}, 32'(sat_count), 0);
  endtask

  task automatic run_layer(input logic [2:0] x, input bit disturb, input bit same_wr);
    int wi, ws, s;
    logic [15:0] wd;
    bit exp_v;
    start = 1'b1;
    x_in  = x;
    if (same_wr) begin
      wi = $urandom_range(0, N-1); ws = $urandom_range(0, 3); wd = 16'($urandom);
      cfg_we = 1'b1; cfg_idx = 4'(wi); cfg_sel = 2'(ws); cfg_data = wd;
      model_write(wi, ws, wd);
    end
    for (int i = 0; i < N; i++) begin
      s = nsum(i, x);
      ea[i] = exp_addr(s);
      if (s < -32768 || s > 32767) exp_sat++;
    end
    @(negedge clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    for (int c = 1; c <= N + L + 3; c++) begin
      x_in = 3'($urandom);
      if (disturb && c == 2) begin
        start = 1'b1; cfg_we = 1'b1;
        cfg_idx = 4'($urandom_range(0, N-1)); cfg_sel = 2'($urandom); cfg_data = 16'($urandom);
      end else if (disturb && c == 3) begin
        start = 1'b0; cfg_we = 1'b0;
      end
      if (c <= N) obs_addr[c-1] = lut_addr;
      chk("lut_addr", 32'(lut_addr), 32'((c <= N) ? ea[c-1] : ea[N-1]));
      exp_v = (c >= 2 + L) && (c <= 1 + L + N);
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        chk("out_idx",  32'(out_idx),  32'(c - 2 - L));
        chk("out_data", 32'(out_data), 32'(lut_fn(ea[c-2-L])));
      end
      chk("busy", 32'(busy), 32'(c <= N + L + 2));
      chk("done", 32'(done), 32'(c == N + L + 2));
      @(negedge clk);
    end
    chk("sat_count", 32'(sat_count), 32'(exp_sat_count()));
  endtask

  function automatic logic [15:0] rand_weight();
    if ($urandom_range(0, 1) == 1) return 16'($urandom);
    return 16'($urandom_range(0, 4000) - 2000);
  endfunction

  initial begin
    int sat_before;
    for (int n = 0; n < 16; n++) for (int s = 0; s < 4; s++) mw[n][s] = 0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    cfg_write(0, 0, 16'd1);
    cfg_write(0, 1, 16'd2);
    cfg_write(0, 2, 16'd3);
    cfg_write(0, 3, 16'd0);
    run_layer(3'b111, 1'b0, 1'b0);
    chk("dir_addr_n0", 32'(obs_addr[0]), 32'h2001);

    cfg_write(1, 3, 16'h8000);
    cfg_write(1, 2, 16'(-100));
    cfg_write(1, 0, 16'd500);
    sat_before = int'(sat_count);
    run_layer(3'b100, 1'b0, 1'b0);
    chk("dir_addr_n1_clamp", 32'(obs_addr[1]), 32'h0000);
`ifdef NEURON_SAT_STATS_EN
    chk("dir_sat_delta", 32'(int'(sat_count) - sat_before), 32'd1);
`else
    chk("dir_sat_delta", 32'(int'(sat_count) - sat_before), 32'd0);
`endif

    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(2, 6)) cfg_write($urandom_range(0, 15), $urandom_range(0, 3), rand_weight());
      run_layer(3'($urandom), (r % 3) == 1, (r % 3) == 2);
    end

    cfg_write(2, 3, 16'd1234);
    run_layer(3'b011, 1'b1, 1'b0);
    run_layer(3'b000, 1'b0, 1'b0);
    chk("dir_bias_kept", 32'(obs_addr[2]), 32'(exp_addr(1234)));

    start = 1'b1; x_in = 3'b111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int n = 0; n < 16; n++) for (int s = 0; s < 4; s++) mw[n][s] = 0;
    exp_sat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 0);
      chk("post_rst_done",  32'(done),      0);
      chk("post_rst_busy",  32'(busy),      0);
    end

    run_layer(3'b101, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      repeat (3) cfg_write($urandom_range(0, N-1), $urandom_range(0, 3), rand_weight());
      run_layer(3'($urandom), 1'b0, r == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neuron_layer_ctrl.md
NEURON_LAYER_CTRL -- requirements
Module: neuron_layer_ctrl

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4, neurons time-multiplexed onto one shared sigmoid LUT (range 1..16).
REQ-002 SHALL have parameter LUT_LATENCY, default 2, cycles from lut_addr change to matching lut_q (range 1..4).
REQ-003 SHALL have port clk, input, 1, sole clock, all state rising-edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request to evaluate the layer.
REQ-006 SHALL have port x_in, input, 3, binary neuron inputs x1..x3 (bit0 = x1).
REQ-007 SHALL have ports cfg_we (1), cfg_idx (4), cfg_sel (2: 0=w1, 1=w2, 2=w3, 3=bias), cfg_data (16, signed), all inputs, for the weight write port.
REQ-008 SHALL have port lut_addr, output, 14, registered sigmoid LUT address.
REQ-009 SHALL have port lut_q, input, 8, sigmoid LUT read data.
REQ-010 SHALL have ports out_valid (1), out_idx (4), out_data (8), all outputs, for the per-neuron result stream.
REQ-011 SHALL have ports busy (1) and done (1), both outputs, giving status and a one-cycle completion pulse.
REQ-012 SHALL have port sat_count, output, 16, count of clamped sums (see REQ-026).

Function
REQ-013 SHALL use FSM states IDLE, RUN, DRAIN, DONE: IDLE->RUN on start; RUN->DRAIN after NUM_NEURONS issue cycles; DRAIN->DONE after LUT_LATENCY+1 cycles; DONE->IDLE after one cycle.
REQ-014 SHALL latch x_in on the cycle start is sampled in IDLE; x_in changes during RUN have no effect.
REQ-015 SHALL ignore start outside IDLE (no queueing, no restart).
REQ-016 SHALL compute, in RUN issue cycle i, sum_i = w1[i]*x1 + w2[i]*x2 + w3[i]*x3 + bias[i] at 32-bit signed width, with no intermediate overflow.
REQ-017 SHALL map sum to a 16-bit address: sum < -32768 -> 0x0000; sum > 32767 -> 0xFFFF; otherwise sum+32768; lut_addr = address[15:2].
REQ-018 SHALL present lut_addr for neuron i in cycle T+1+i, where T is the start cycle; lut_addr holds its last value outside RUN.
REQ-019 SHALL capture lut_q via a LUT_LATENCY-deep valid/index shift pipeline and assert out_valid with out_idx=i, out_data=lut_q in cycle T+2+i+LUT_LATENCY, one neuron per cycle, in index order.
REQ-020 SHALL assert busy in RUN, DRAIN and DONE, and assert done for exactly the DONE cycle, i.e. the cycle after the last out_valid.
REQ-021 SHALL apply cfg_we writes only in IDLE; writes while busy=1 are dropped, as are writes with cfg_idx >= NUM_NEURONS.
REQ-022 SHALL let a cfg write and start in the same IDLE cycle both take effect, with the write visible to the run that start begins.

Reset
REQ-023 SHALL, on rst_n low, asynchronously force: FSM=IDLE, busy=0, done=0, out_valid=0, out_idx=0, out_data=0, lut_addr=0, sat_count=0, pipeline valids=0, and all weights and biases=0.
REQ-024 SHALL abort a mid-run reset with no further out_valid/done until a new start.

Configuration
REQ-025 SHALL compile the saturation counter only when macro NEURON_SAT_STATS_EN is defined.
REQ-026 SHALL, with the macro, increment sat_count once per issued neuron whose sum was clamped (either bound), saturating at 0xFFFF and never wrapping; without it, sat_count is tied to 0 and no counter logic exists.

Structure
REQ-027 SHALL take state enum, WEIGHT_W=16, SUM_W=32, SUM_MIN=-32768, SUM_MAX=32767, ADDR_OFFSET=32768 from shared package neuron_pkg.
REQ-028 SHALL put REQ-017 clamping in sub-module neuron_sat_addr (32-bit signed in, 16-bit address and clamped flag out, combinational).

Verification
REQ-029 SHALL cover: weights w=(1,2,3), bias=0 for neuron 0, x_in=3'b111, start -> lut_addr=(6+32768)>>2=0x2001 in cycle T+1, out_valid with out_idx=0 in cycle T+4 (LUT_LATENCY=2).
REQ-030 SHALL cover: bias=-32768 (0x8000) for neuron 1, w3=-100, x_in=3'b100 -> lut_addr=0x0000; sat_count increments by 1 with the macro, stays 0 without.
REQ-031 SHALL cover: NUM_NEURONS=4 run -> out_idx 0,1,2,3 on consecutive cycles, done one cycle after idx 3, busy low next cycle.
REQ-032 SHALL cover: start and cfg_we pulsed mid-run -> run unchanged, weight unchanged on the next run.
REQ-033 SHALL cover: rst_n low in cycle T+2 -> all outputs 0 immediately; no out_valid until the next start.
